io_param_loader: RTL and testbench

//  Streams CNN weights, FC weights or image pixels from a valid/ready word stream into the accelerator parameter memory.

---
 rtl/io_loader_pkg.sv | 24 ++
 rtl/io_prio_enc.sv | 24 ++
 rtl/io_param_loader.sv | 170 +++++++++++++++++
 tb/tb_io_param_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_loader_pkg.sv
// io_loader_pkg: shared types and constants for the parameter loader.
//   state_t     : loader FSM states (IDLE, LOAD, CHECK, DONE)
//   ERR_*       : err_code values reported at the end of a load
//   RGN_*       : region indices (CNN, FC, IMG)
// Optional feature macro: IO_LOADER_CHECKSUM_EN (CHECK state only used when defined).
package io_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_EARLY   = 2'd1;  // s_last before the expected final word
    localparam logic [1:0] ERR_MISSING = 2'd2;  // final word arrived without s_last
    localparam logic [1:0] ERR_CSUM    = 2'd3;  // checksum word disagrees with payload sum

    localparam int RGN_CNN = 0;
    localparam int RGN_FC  = 1;
    localparam int RGN_IMG = 2;

endpackage

// File: rtl/io_prio_enc.sv
// io_prio_enc: lowest-set-bit priority encoder.
//   req [N-1:0] in  : request vector
//   idx [W-1:0] out : index of the lowest set bit (0 when none)
//   any         out : at least one request bit set
module io_prio_enc #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the top down so the lowest set bit is the last to write idx.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = W'(i);
        end
    end

    assign any = |req;

endmodule

// File: rtl/io_param_loader.sv
// io_param_loader: streams words from a valid/ready source into the parameter
// memory for one of NUM_REGIONS regions, length-checked against word_cnt.
// Optional feature macro: IO_LOADER_CHECKSUM_EN -- an extra trailing checksum
// word (sum of payload mod 2^DATA_W) is accepted, compared and not written.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start[NUM_REGIONS]         one-cycle load request (lowest set bit wins)
//   base_addr, word_cnt        load parameters, sampled with start
//   s_valid/s_ready/s_data/s_last  input word stream
//   mem_we/mem_addr/mem_wdata/mem_region  registered memory write port
//   busy                       load in progress
//   finish[NUM_REGIONS]        sticky per-region success flag
//   done_pulse                 one-cycle end-of-load strobe
//   err, err_code              outcome of the last load
module io_param_loader
    import io_loader_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int CNT_W       = 16,
    parameter int NUM_REGIONS = 3,
    parameter int RGN_W       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REGIONS-1:0] start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [CNT_W-1:0]       word_cnt,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_W-1:0]      s_data,
    input  logic                   s_last,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic [RGN_W-1:0]       mem_region,
    output logic                   busy,
    output logic [NUM_REGIONS-1:0] finish,
    output logic                   done_pulse,
    output logic                   err,
    output logic [1:0]             err_code
);

    state_t            state, state_nxt;
    logic [1:0]        code_nxt;
    logic [RGN_W-1:0]  rgn, enc_idx;
    logic              enc_any;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  cnt, idx;
    logic              hs, last_pay;
`ifdef IO_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] acc;
`endif

    io_prio_enc #(.N(NUM_REGIONS), .W(RGN_W)) u_enc (
        .req (start),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign s_ready    = (state == LOAD) || (state == CHECK);
    assign hs         = s_valid & s_ready;
    // Only evaluated in LOAD, where cnt is known non-zero.
    assign last_pay   = (idx == cnt - CNT_W'(1));
    assign busy       = (state != IDLE);
    assign done_pulse = (state == DONE);
    assign mem_region = rgn;

    always_comb begin
        state_nxt = state;
        code_nxt  = err_code;
        case (state)
            IDLE: begin
                if (enc_any) begin
                    code_nxt  = ERR_NONE;
                    state_nxt = (word_cnt == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (hs) begin
                    if (last_pay) begin
`ifdef IO_LOADER_CHECKSUM_EN
                        // s_last belongs on the checksum word, not the payload.
                        if (s_last) begin
                            code_nxt  = ERR_EARLY;
                            state_nxt = DONE;
                        end else begin
                            state_nxt = CHECK;
                        end
`else
                        if (!s_last) code_nxt = ERR_MISSING;
                        state_nxt = DONE;
`endif
                    end else if (s_last) begin
                        code_nxt  = ERR_EARLY;
                        state_nxt = DONE;
                    end
                end
            end
            CHECK: begin
`ifdef IO_LOADER_CHECKSUM_EN
                if (hs) begin
                    state_nxt = DONE;
                    if (!s_last)          code_nxt = ERR_MISSING;
                    else if (s_data != acc) code_nxt = ERR_CSUM;
                end
`else
                // Unreachable without the checksum feature.
                state_nxt = IDLE;
`endif
            end
            DONE: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            err_code  <= ERR_NONE;
            err       <= 1'b0;
            finish    <= '0;
            rgn       <= '0;
            base      <= '0;
            cnt       <= '0;
            idx       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef IO_LOADER_CHECKSUM_EN
            acc       <= '0;
`endif
        end else begin
            state    <= state_nxt;
            err_code <= code_nxt;
            mem_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (enc_any) begin
                        rgn             <= enc_idx;
                        base            <= base_addr;
                        cnt             <= word_cnt;
                        idx             <= '0;
                        finish[enc_idx] <= 1'b0;
                        err             <= 1'b0;
`ifdef IO_LOADER_CHECKSUM_EN
                        acc             <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (hs) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= base + ADDR_W'(idx);  // wraps modulo 2^ADDR_W
                        mem_wdata <= s_data;
                        idx       <= idx + CNT_W'(1);
`ifdef IO_LOADER_CHECKSUM_EN
                        acc       <= acc + s_data;
`endif
                    end
                end
                DONE: begin
                    if (err_code == ERR_NONE) finish[rgn] <= 1'b1;
                    err <= (err_code != ERR_NONE);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_param_loader.sv
// tb_io_param_loader: directed and randomized loads checked against a
// word-list reference model of the loader.
module tb_io_param_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start = '0;
    logic [15:0] base_addr = '0;
    logic [15:0] word_cnt = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_region;
    logic        busy;
    logic [2:0]  finish;
    logic        done_pulse;
    logic        err;
    logic [1:0]  err_code;

    io_param_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_cnt(word_cnt), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_region(mem_region), .busy(busy),
        .finish(finish), .done_pulse(done_pulse), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
        logic [1:0]  r;
    } wr_t;

    wr_t         wq[$];
    int          dp_cnt = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] d[0:19];
    logic        l[0:19];
    logic [2:0]  exp_fin = '0;

    // Observe the write port and the end strobe away from the rising edge.
    always @(negedge clk) begin
        if (mem_we) wq.push_back({mem_addr, mem_wdata, mem_region});
        if (done_pulse) dp_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Build a stream: mode 0 well-formed, 1 early s_last at epos, 2 no s_last,
    // 3 well-formed but with a wrong checksum word.
    task automatic gen(input int n, input int mode, input int epos, input bit seq);
        logic [15:0] sum;
        sum = '0;
        for (int i = 0; i < 20; i++) begin
            d[i] = seq ? 16'(i + 1) : 16'($urandom);
            l[i] = 1'b0;
        end
        for (int i = 0; i < n; i++) sum = sum + d[i];
        d[n] = (mode == 3) ? sum + 16'd1 : sum;
        if (mode == 1) l[epos] = 1'b1;
`ifdef IO_LOADER_CHECKSUM_EN
        if (mode == 0 || mode == 3) l[n] = 1'b1;
`else
        if ((mode == 0 || mode == 3) && n > 0) l[n-1] = 1'b1;
`endif
    endtask

    // Expected number of memory writes and err_code for the current stream.
    task automatic model(input int n, output int nw, output logic [1:0] code);
        logic [15:0] sum;
        nw = 0;
        code = 2'd0;
        sum = '0;
        for (int k = 0; k < n; k++) begin
            nw = k + 1;
            sum = sum + d[k];
            if (k == n - 1) begin
`ifdef IO_LOADER_CHECKSUM_EN
                if (l[k])           code = 2'd1;
                else if (!l[n])     code = 2'd2;
                else if (d[n] != sum) code = 2'd3;
`else
                if (!l[k]) code = 2'd2;
`endif
            end else if (l[k]) begin
                code = 2'd1;
                break;
            end
        end
    endtask

    task automatic do_load(input logic [2:0] sv, input logic [15:0] b, input int n,
                           input bit gaps, input bit noise);
        int         nw, k, cyc, r;
        logic [1:0] code;
        bit         v;
        wq.delete();
        dp_cnt = 0;
        r = 0;
        for (int i = 2; i >= 0; i--) if (sv[i]) r = i;
        model(n, nw, code);
        exp_fin[r] = (code == 2'd0);
        @(negedge clk);
        start = sv;
        base_addr = b;
        word_cnt = 16'(n);
        k = 0;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            if (!busy || cyc > 100) break;
            cyc++;
            start = noise ? 3'($urandom) : 3'd0;
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_valid = v;
            s_data = d[k];
            s_last = v & l[k];
            if (v && s_ready && k < 19) k++;
        end
        start = '0;
        s_valid = 1'b0;
        s_last = 1'b0;
        chk("timeout", 64'(cyc <= 100), 64'd1);
        chk("done_pulse_count", 64'(dp_cnt), 64'd1);
        chk("write_count", 64'(wq.size()), 64'(nw));
        for (int i = 0; i < nw && i < wq.size(); i++)
            chk("write", 64'(wq[i]), 64'({b + 16'(i), d[i], 2'(r)}));
        chk("err_code", 64'(err_code), 64'(code));
        chk("err", 64'(err), 64'(code != 2'd0));
        chk("finish", 64'(finish), 64'(exp_fin));
        chk("idle_after", 64'({busy, s_ready, mem_we, done_pulse}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no end, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, mode, epos;
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({mem_we, busy, s_ready, done_pulse, err, err_code, finish}), 64'd0);
        chk("reset_bus", 64'({mem_addr, mem_wdata, mem_region}), 64'd0);
        rst_n = 1'b1;

        // 1: region 0, base 0x0100, data 1..4
        gen(4, 0, 0, 1'b1);
        do_load(3'b001, 16'h0100, 4, 1'b0, 1'b0);
        // 2: two requests in one cycle, lowest wins
        gen(2, 0, 0, 1'b0);
        do_load(3'b110, 16'h0040, 2, 1'b0, 1'b0);
        // 3: early s_last on word 2 of 4
        gen(4, 1, 1, 1'b0);
        do_load(3'b010, 16'h0300, 4, 1'b0, 1'b0);
        // 4: address wrap with valid gaps
        gen(3, 0, 0, 1'b0);
        do_load(3'b100, 16'hFFFF, 3, 1'b1, 1'b0);
        // missing s_last
        gen(3, 2, 0, 1'b0);
        do_load(3'b001, 16'h1000, 3, 1'b0, 1'b0);

        // 5: reset during word 2 of 5
        gen(5, 0, 0, 1'b0);
        @(negedge clk);
        start = 3'b100; base_addr = 16'h0200; word_cnt = 16'd5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = '0; s_valid = 1'b1; s_data = d[k]; s_last = l[k];
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midload_reset_outputs", 64'({mem_we, busy, s_ready, done_pulse, err, err_code, finish}), 64'd0);
        chk("midload_reset_bus", 64'({mem_addr, mem_wdata, mem_region}), 64'd0);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        rst_n = 1'b1;
        exp_fin = '0;
        gen(5, 0, 0, 1'b0);
        do_load(3'b100, 16'h0200, 5, 1'b0, 1'b0);

        // zero-length load: done_pulse in the cycle after start, no writes
        wq.delete();
        @(negedge clk);
        start = 3'b010; word_cnt = 16'd0; base_addr = 16'h0777;
        @(negedge clk);
        start = '0;
        chk("cnt0_done_cycle2", 64'({done_pulse, busy, s_ready}), 64'b110);
        @(negedge clk);
        exp_fin[1] = 1'b1;
        chk("cnt0_after", 64'({done_pulse, busy, err, finish}), 64'({3'b000, exp_fin}));
        chk("cnt0_no_writes", 64'(wq.size()), 64'd0);

`ifdef IO_LOADER_CHECKSUM_EN
        // 6: checksum good then bad
        gen(2, 0, 0, 1'b0);
        d[0] = 16'd5; d[1] = 16'd6; d[2] = 16'd11;
        do_load(3'b001, 16'h0010, 2, 1'b0, 1'b0);
        d[2] = 16'd12;
        do_load(3'b001, 16'h0010, 2, 1'b0, 1'b0);
`endif

        // randomized loads, start noise while busy
        for (int it = 0; it < 14; it++) begin
            n = $urandom_range(1, 8);
            mode = $urandom_range(0, 3);
            if (mode == 1 && n == 1) mode = 0;
            epos = (n > 1) ? $urandom_range(0, n - 2) : 0;
            gen(n, mode, epos, 1'b0);
            do_load(3'($urandom_range(1, 7)), 16'($urandom), n, 1'($urandom), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
